// File: rtl/cybercobra_core_p.sv
// cybercobra_core_p: parametrised single-cycle CYBERcobra core.
// One 32-bit instruction per clock from a combinational ROM, generic-width
// register file and ALU, switch input with valid/ready handshake, sticky
// HALT and a saturating retired-instruction counter.
module cybercobra_core_p #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int PC_W    = 10,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [PC_W-1:0]   instr_addr_o,
    input  logic [31:0]       instr_i,
    input  logic [15:0]       sw_i,
    input  logic              sw_valid_i,
    output logic              sw_ready_o,
    output logic [DATA_W-1:0] out_o,
    output logic              halted_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  retired_o
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LT   = 5'b11100;
    localparam logic [4:0] ALU_GE   = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    localparam logic [1:0] WS_CONST = 2'b00;
    localparam logic [1:0] WS_ALU   = 2'b01;
    localparam logic [1:0] WS_SW    = 2'b10;

    // State
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [DATA_W-1:0] rf_q [REG_NUM];
    logic [DATA_W-1:0] rf_d [REG_NUM];

    // Instruction fields
    logic              is_j_s, is_b_s;
    logic [1:0]        ws_s;
    logic [4:0]        alu_op_s, ra1_s, ra2_s, wa_s;
    logic [PC_W-1:0]   offs_s;

    // Datapath
    logic [DATA_W-1:0] rd_a_s, rd_b_s, alu_res_s, wd_s;
    logic [SH_W-1:0]   shamt_s;
    logic              alu_flag_s;
    logic              is_sw_s, stall_s, retire_s, we_s;

    assign is_j_s   = instr_i[31];
    assign is_b_s   = instr_i[30];
    assign ws_s     = instr_i[29:28];
    assign alu_op_s = instr_i[27:23];
    assign ra1_s    = instr_i[22:18];
    assign ra2_s    = instr_i[17:13];
    assign wa_s     = instr_i[4:0];
    // Branch/jump displacement: signed word offset turned into a byte offset.
    assign offs_s   = PC_W'($signed({instr_i[12:5], 2'b00}));
    assign shamt_s  = rd_b_s[SH_W-1:0];

    // Switch handshake: a switch write either consumes sw_i or stalls the core.
    assign is_sw_s  = !is_j_s && !is_b_s && (ws_s == WS_SW) && !halted_q;
    assign stall_s  = is_sw_s && !sw_valid_i;
    assign retire_s = !halted_q && !stall_s;
    assign we_s     = !is_j_s && !is_b_s && (ws_s != 2'b11) && !halted_q && !stall_s;

    // Read ports; reg 0 and addresses beyond REG_NUM read as zero.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            rd_a_s = (ra1_s == 5'(i)) ? rf_q[i] : rd_a_s;
            rd_b_s = (ra2_s == 5'(i)) ? rf_q[i] : rd_b_s;
        end
    end

    // ALU: result ops produce a value, flag ops only raise the branch flag.
    always_comb begin
        alu_res_s  = '0;
        alu_flag_s = 1'b0;
        case (alu_op_s)
            ALU_ADD:  alu_res_s = rd_a_s + rd_b_s;
            ALU_SUB:  alu_res_s = rd_a_s - rd_b_s;
            ALU_SLL:  alu_res_s = rd_a_s << shamt_s;
            ALU_SLT:  alu_res_s = DATA_W'($signed(rd_a_s) < $signed(rd_b_s));
            ALU_SLTU: alu_res_s = DATA_W'(rd_a_s < rd_b_s);
            ALU_XOR:  alu_res_s = rd_a_s ^ rd_b_s;
            ALU_SRL:  alu_res_s = rd_a_s >> shamt_s;
            ALU_SRA:  alu_res_s = $signed(rd_a_s) >>> shamt_s;
            ALU_OR:   alu_res_s = rd_a_s | rd_b_s;
            ALU_AND:  alu_res_s = rd_a_s & rd_b_s;
            ALU_EQ:   alu_flag_s = (rd_a_s == rd_b_s);
            ALU_NE:   alu_flag_s = (rd_a_s != rd_b_s);
            ALU_LT:   alu_flag_s = ($signed(rd_a_s) < $signed(rd_b_s));
            ALU_GE:   alu_flag_s = ($signed(rd_a_s) >= $signed(rd_b_s));
            ALU_LTU:  alu_flag_s = (rd_a_s < rd_b_s);
            ALU_GEU:  alu_flag_s = (rd_a_s >= rd_b_s);
            default: begin
                alu_res_s  = '0;
                alu_flag_s = 1'b0;
            end
        endcase
    end

    // Write-data select: constant (sign-extended or truncated), ALU, switches.
    always_comb begin
        wd_s = '0;
        case (ws_s)
            WS_CONST: wd_s = DATA_W'($signed(instr_i[27:5]));
            WS_ALU:   wd_s = alu_res_s;
            WS_SW:    wd_s = DATA_W'(sw_i);
            default:  wd_s = '0;
        endcase
    end

    // Register-file update; reg 0 is never written and out-of-range WA is dropped.
    always_comb begin
        rf_d = rf_q;
        for (int i = 1; i < REG_NUM; i++) begin
            rf_d[i] = (we_s && (wa_s == 5'(i))) ? wd_s : rf_q[i];
        end
    end

    // Next PC, HALT latch and saturating retirement count.
    always_comb begin
        pc_d      = pc_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (!retire_s) begin
            pc_d = pc_q;
        end else if (is_j_s && is_b_s) begin
            halted_d = 1'b1;
        end else if (is_j_s || (is_b_s && alu_flag_s)) begin
            pc_d = pc_q + offs_s;
        end else begin
            pc_d = pc_q + PC_W'(3'd4);
        end
        if (retire_s && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1'b1);
        end else begin
            retired_d = retired_q;
        end
    end

    // Architectural state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign instr_addr_o = pc_q;
    assign halted_o     = halted_q;
    assign retired_o    = retired_q;
    assign stall_o      = stall_s;
    assign sw_ready_o   = is_sw_s && sw_valid_i;
    assign out_o        = rd_a_s;

endmodule

// File: tb/tb_cybercobra_core_p.sv
// Bench for cybercobra_core_p: two instances (default and DATA_W=16/REG_NUM=8/
// CNT_W=4) checked every cycle against an instruction-level reference model.
module tb_cybercobra_core_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] sw;
    logic        sw_valid;
    logic [31:0] rom [2][256];

    logic [9:0]  pc0, pc1;
    logic [31:0] ins0, ins1;
    logic        rdy0, rdy1, hlt0, hlt1, stl0, stl1;
    logic [31:0] out0;
    logic [15:0] out1;
    logic [15:0] ret0;
    logic [3:0]  ret1;

    assign ins0 = rom[0][pc0[9:2]];
    assign ins1 = rom[1][pc1[9:2]];

    cybercobra_core_p dut0 (
        .clk_i(clk), .rst_i(rst_n), .instr_addr_o(pc0), .instr_i(ins0),
        .sw_i(sw), .sw_valid_i(sw_valid), .sw_ready_o(rdy0), .out_o(out0),
        .halted_o(hlt0), .stall_o(stl0), .retired_o(ret0)
    );

    cybercobra_core_p #(.DATA_W(16), .REG_NUM(8), .PC_W(10), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .instr_addr_o(pc1), .instr_i(ins1),
        .sw_i(sw), .sw_valid_i(sw_valid), .sw_ready_o(rdy1), .out_o(out1),
        .halted_o(hlt1), .stall_o(stl1), .retired_o(ret1)
    );

    // Reference model: architectural state of each instance
    int          DW [2] = '{32, 16};
    int          RN [2] = '{32, 8};
    int          CW [2] = '{16, 4};
    logic [63:0] m_rf [2][32];
    int          m_pc [2];
    bit          m_halt [2];
    longint      m_ret [2];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] s_out [2];
    bit          s_stall [2];
    bit          s_ready [2];

    localparam logic [31:0] NOP = 32'h3000_0000;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0;
            m_halt[k] = 1'b0;
            m_ret[k] = 0;
            for (int r = 0; r < 32; r++) m_rf[k][r] = 64'd0;
        end
    endtask

    // Execute one instruction of instance k; return what its combinational outputs must show.
    task automatic model_step(input int k, output bit e_stall, output bit e_ready, output logic [63:0] e_out);
        logic [31:0] w;
        bit j, b, flag;
        int ws, op, ra1, ra2, wa, offs, sh;
        logic [63:0] mask, a, bv, res, wd;
        logic signed [63:0] sa, sb;
        w = rom[k][(m_pc[k] >> 2) & 255];
        j = w[31]; b = w[30];
        ws = int'(w[29:28]); op = int'(w[27:23]);
        ra1 = int'(w[22:18]); ra2 = int'(w[17:13]); wa = int'(w[4:0]);
        offs = int'($signed(w[12:5]));
        mask = (DW[k] == 64) ? {64{1'b1}} : ((64'd1 << DW[k]) - 64'd1);
        a  = (ra1 < RN[k]) ? m_rf[k][ra1] : 64'd0;
        bv = (ra2 < RN[k]) ? m_rf[k][ra2] : 64'd0;
        sa = $signed(sx(a, DW[k]));
        sb = $signed(sx(bv, DW[k]));
        sh = int'(bv) & (DW[k] - 1);
        res = 64'd0;
        flag = 1'b0;
        case (op)
            0:  res = a + bv;
            8:  res = a - bv;
            1:  res = a << sh;
            2:  res = (sa < sb) ? 64'd1 : 64'd0;
            3:  res = (a < bv) ? 64'd1 : 64'd0;
            4:  res = a ^ bv;
            5:  res = a >> sh;
            13: res = sa >>> sh;
            6:  res = a | bv;
            7:  res = a & bv;
            24: flag = (a == bv);
            25: flag = (a != bv);
            28: flag = (sa < sb);
            29: flag = (sa >= sb);
            30: flag = (a < bv);
            31: flag = (a >= bv);
            default: res = 64'd0;
        endcase
        res = res & mask;
        case (ws)
            0: wd = sx({41'd0, w[27:5]}, 23) & mask;
            1: wd = res;
            default: wd = {48'd0, sw} & mask;
        endcase
        e_out = a;
        e_stall = 1'b0;
        e_ready = 1'b0;
        if (!m_halt[k]) begin
            if (!j && !b && ws == 2) begin
                e_stall = !sw_valid;
                e_ready = sw_valid;
            end
            if (!e_stall) begin
                if (!j && !b && ws != 3 && wa != 0 && wa < RN[k]) m_rf[k][wa] = wd;
                if (j && b) m_halt[k] = 1'b1;
                else if (j || (b && flag)) m_pc[k] = (m_pc[k] + 4 * offs) & 1023;
                else m_pc[k] = (m_pc[k] + 4) & 1023;
                if (m_ret[k] < ((longint'(1) << CW[k]) - 1)) m_ret[k]++;
            end
        end
    endtask

    // One clock: compare both instances against the model mid-cycle, then advance.
    task automatic step();
        bit es, er;
        logic [63:0] eo;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("pc%0d", k), (k == 0) ? 64'(pc0) : 64'(pc1), 64'(m_pc[k]));
            check_eq($sformatf("halted%0d", k), (k == 0) ? 64'(hlt0) : 64'(hlt1), 64'(m_halt[k]));
            check_eq($sformatf("retired%0d", k), (k == 0) ? 64'(ret0) : 64'(ret1), 64'(m_ret[k]));
            s_out[k]   = (k == 0) ? 64'(out0) : 64'(out1);
            s_stall[k] = (k == 0) ? stl0 : stl1;
            s_ready[k] = (k == 0) ? rdy0 : rdy1;
            model_step(k, es, er, eo);
            check_eq($sformatf("out%0d", k), s_out[k], eo);
            check_eq($sformatf("stall%0d", k), 64'(s_stall[k]), 64'(es));
            check_eq($sformatf("ready%0d", k), 64'(s_ready[k]), 64'(er));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc0"}, 64'(pc0), 64'd0);
        check_eq({tag, "_ret0"}, 64'(ret0), 64'd0);
        check_eq({tag, "_hlt0"}, 64'(hlt0), 64'd0);
        check_eq({tag, "_out0"}, 64'(out0), 64'd0);
        check_eq({tag, "_pc1"}, 64'(pc1), 64'd0);
        check_eq({tag, "_hlt1"}, 64'(hlt1), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reset asserted between clock edges: outputs must clear without an edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_rom(input int k);
        for (int i = 0; i < 256; i++) rom[k][i] = NOP;
    endtask

    initial begin
        int cyc;
        int rdy_cnt;
        logic [31:0] w;
        rst_n = 1'b0;
        sw = 16'd0;
        sw_valid = 1'b0;
        clear_rom(0);
        clear_rom(1);
        model_reset();
        // Narrow instance: const truncation, out-of-range reg, sra
        rom[1][0] = 32'h0FFF_FFE1;
        rom[1][1] = 32'h3004_0000;
        rom[1][2] = 32'h0000_00A9;
        rom[1][3] = 32'h3024_0000;
        rom[1][4] = 32'h0010_0002;
        rom[1][5] = 32'h0000_01E3;
        rom[1][6] = 32'h1688_6004;
        rom[1][7] = 32'hC010_0000;

        // Reset and first edge with a NOP at PC 0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                check_eq("first_pc", 64'(pc0), 64'd4);
                check_eq("first_ret", 64'(ret0), 64'd1);
            end
            if (i == 1) check_eq("n_const_trunc", s_out[1], 64'hFFFF);
            if (i == 3) check_eq("n_reg9_zero", s_out[1], 64'h0);
            if (i == 7) check_eq("n_sra", s_out[1], 64'hFFFF);
        end
        check_eq("n_halted", 64'(hlt1), 64'd1);
        check_eq("n_retired", 64'(ret1), 64'd8);

        // Counter program
        clear_rom(0);
        rom[0][0] = 32'h2000_0001;
        rom[0][1] = 32'h0000_0022;
        rom[0][2] = 32'h100C_4003;
        rom[0][3] = 32'h4C8C_3FE0;
        rom[0][4] = 32'hC00C_0000;
        sw = 16'h0108;
        sw_valid = 1'b1;
        do_reset();
        cyc = 0;
        while (hlt0 !== 1'b1 && cyc < 1200) begin
            step();
            cyc++;
        end
        check_eq("cnt_halted", 64'(hlt0), 64'd1);
        check_eq("cnt_out", 64'(out0), 64'h108);
        check_eq("cnt_retired", 64'(ret0), 64'd531);
        step();
        check_eq("cnt_hold_pc", 64'(pc0), 64'd16);
        check_eq("cnt_hold_ret", 64'(ret0), 64'd531);

        // Switch stall then handshake
        clear_rom(0);
        rom[0][0] = 32'h2000_0005;
        rom[0][1] = 32'h3014_0000;
        sw_valid = 1'b0;
        sw = 16'h1111;
        do_reset();
        rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_flag", 64'(s_stall[0]), 64'd1);
            check_eq("stall_pc", 64'(pc0), 64'd0);
            rdy_cnt += int'(s_ready[0]);
        end
        sw = 16'hBEEF;
        sw_valid = 1'b1;
        step();
        rdy_cnt += int'(s_ready[0]);
        check_eq("sw_ret", 64'(ret0), 64'd1);
        sw_valid = 1'b0;
        step();
        rdy_cnt += int'(s_ready[0]);
        check_eq("sw_value", s_out[0], 64'h0000_BEEF);
        check_eq("ready_once", 64'(rdy_cnt), 64'd1);

        // Jump with most negative offset wraps
        clear_rom(0);
        rom[0][0] = 32'h8000_1000;
        do_reset();
        step();
        check_eq("jump_wrap", 64'(pc0), 64'd512);

        // Signed vs unsigned branch, write to reg 0, halt
        clear_rom(0);
        rom[0][0] = 32'h0FFF_FFE1;
        rom[0][1] = 32'h4E04_0040;
        rom[0][3] = 32'h4F04_0080;
        rom[0][4] = 32'h0000_00A0;
        rom[0][5] = 32'hC000_0000;
        do_reset();
        step();
        step();
        check_eq("blt_taken", 64'(pc0), 64'd12);
        step();
        check_eq("bltu_not", 64'(pc0), 64'd16);
        step();
        step();
        check_eq("r0_zero", s_out[0], 64'd0);
        check_eq("br_halted", 64'(hlt0), 64'd1);

        // Asynchronous reset while halted, then restart from PC 0
        async_reset("ahlt");
        step();
        check_eq("ahlt_resume", 64'(pc0), 64'd4);
        repeat (4) step();

        // Asynchronous reset while stalled
        clear_rom(0);
        rom[0][1] = 32'h2000_0005;
        rom[0][2] = 32'h3014_0000;
        sw_valid = 1'b0;
        do_reset();
        repeat (3) step();
        check_eq("pre_stall", 64'(stl0), 64'd1);
        async_reset("astl");
        check_eq("astl_stall", 64'(stl0), 64'd0);
        sw = 16'h1234;
        sw_valid = 1'b1;
        repeat (3) step();
        check_eq("astl_resume", s_out[0], 64'h1234);

        // Randomized programs on both instances
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 256; i++) begin
                    w = $urandom;
                    if (w[31:30] == 2'b11 && $urandom_range(0, 9) != 0) w[31] = 1'b0;
                    rom[k][i] = w;
                end
            end
            do_reset();
            for (int c = 0; c < 200; c++) begin
                sw = 16'($urandom);
                sw_valid = ($urandom_range(0, 9) < 7);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cybercobra_core_p.md
Name: cybercobra_core_p

Overview:
- Parametrised successor core for the lab-04 single-cycle CYBERcobra machine.
- Executes one 32-bit instruction per clock from an external combinational instruction ROM.
- Provides a generic-width register file and data path, plus an on-chip ALU.
- Adds a valid/ready handshake on the switch input, a HALT instruction with a sticky status output, and a retired-instruction counter.
- Sits between the board wrapper (switches, 7-seg or LED output) and an instruction-memory module.

Parameters:
- DATA_W, 32: register/ALU/output width; legal range 8..64.
- REG_NUM, 32: number of registers; legal range 2..32. Reg 0 is hardwired to zero. Writes to addresses >= REG_NUM are ignored; reads from them return 0.
- PC_W, 10: byte-address width of the instruction port; PC wraps modulo 2^PC_W.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset. Asynchronous, active-low.
- instr_addr_o, out, PC_W: current PC, byte address, always a multiple of 4.
- instr_i, in, 32: instruction at instr_addr_o, same cycle.
- sw_i, in, 16: switch data.
- sw_valid_i, in, 1: sw_i holds a value available for consumption.
- sw_ready_o, out, 1: core consumes sw_i this cycle.
- out_o, out, DATA_W: combinational read of register RA1 of the current instruction.
- halted_o, out, 1: sticky HALT status.
- stall_o, out, 1: core is waiting on sw_valid_i.
- retired_o, out, CNT_W: count of retired instructions; saturates at all-ones.

Behaviour:
- Instruction fields:
  - [31] J, [30] B, [29:28] WS, [27:23] ALUop.
  - [22:18] RA1, [17:13] RA2, [12:5] OFFS (signed), [4:0] WA.
  - CONST = [27:5], 23 bits.
- Register file:
  - REG_NUM x DATA_W registers, two combinational read ports, one write port.
  - All registers reset to 0.
- Write data selected by WS:
  - 00: CONST sign-extended, or truncated if DATA_W < 23.
  - 01: ALU result.
  - 10: sw_i zero-extended to DATA_W.
  - 11: no write.
- Write enable = !J && !B && WS != 11 && !halted && !stall.
- ALU operands: A = rf[RA1], B = rf[RA2].
- ALU result ops:
  - 00000 add; 01000 sub; 00001 sll, shift by B[log2(DATA_W)-1:0]; 00010 slt; 00011 sltu.
  - 00100 xor; 00101 srl; 01101 sra; 00110 or; 00111 and.
- ALU flag ops: 11000 eq, 11001 ne, 11100 lt, 11101 ge, 11110 ltu, 11111 geu.
- Flag definition: set only for flag ops, 0 otherwise. Result is 0 for flag ops and 0 for undefined codes. Undefined codes never stall or trap.
- Next PC, in priority order:
  - Reset: 0.
  - Halted or stalled: hold.
  - J=1 and B=1: HALT. Set halted_o on this edge; PC holds; no write.
  - J=1: PC + (sext(OFFS) << 2).
  - B=1 and flag=1: PC + (sext(OFFS) << 2).
  - Otherwise: PC + 4.
  - All PC arithmetic is modulo 2^PC_W.
- Switch handshake:
  - Stall condition: instruction with WS=10, J=0, B=0, not halted, and sw_valid_i=0. Then stall_o=1, PC holds, no write.
  - When sw_valid_i=1 for such an instruction: sw_ready_o=1 in that cycle, rf[WA] <= sw_i at the edge, PC advances.
  - sw_ready_o is 0 in every other cycle.
  - sw_valid_i is ignored for non-switch instructions.
- Retirement counter:
  - retired_o increments on every edge where the PC advances or a jump/branch is taken. HALT itself counts as retired.
  - Stall cycles and halted cycles do not increment.
  - Saturates at 2^CNT_W - 1.
- Reset values: instr_addr_o=0, out_o=0, halted_o=0, stall_o and sw_ready_o are 0 or as determined by the instruction at PC 0, retired_o=0.
- Reset asserted mid-stall or while halted: everything returns to reset values asynchronously; execution restarts at PC 0 on the first edge after release.
- Simultaneous HALT and switch instruction cannot occur (J=B=1 excludes switch write).
- Halted core ignores sw_valid_i; sw_ready_o stays 0.

Test Plan:
- Reset: rst_i=0 for 2 cycles, then release with instr[0]=NOP (WS=11) -> instr_addr_o=0, retired_o=0, halted_o=0 during reset; PC=4, retired_o=1 after the first edge.
- Counter program with sw_valid_i=1, sw_i=16'h0108:
  - Program: r1=sw; r2=const 1; loop r3=r3+r2; branch ne r3,r1 back one; halt.
  - Required: r3 ends at 0x108, halted_o=1, out_o=0x108 with RA1=3 at the halt word.
  - retired_o = 2 + 2*0x108 + 1 = 531.
- Switch stall: sw_valid_i=0 for 5 cycles during a WS=10 instruction, then 1 with sw_i=16'hBEEF -> stall_o=1 and PC constant for 5 cycles; sw_ready_o=1 for exactly one cycle; rf[WA]=0x0000BEEF; retired_o +1 only.
- Branch/jump boundaries:
  - J with OFFS=8'h80 at PC 0 -> PC = 2^PC_W - 512 (wrap).
  - Branch lt with -1 vs 0 -> taken; ltu -> not taken.
  - Write to reg 0 -> reads stay 0.
- Parameter sweep DATA_W=16, REG_NUM=8:
  - CONST=23'h7FFFFF -> 0xFFFF.
  - Write to WA=9 ignored; read RA1=9 -> 0.
  - sra 0x8000 by 15 -> 0xFFFF.
- Async reset while halted and while stalled -> all outputs reset immediately, without waiting for a clock edge; normal execution resumes from PC 0.
